key_input: RTL and testbench
============================

Name: key_input

Overview:
- Debounces the board push-buttons and turns them into clean per-key level and event signals for the W5300 debug design.
- Sits on the human-input side of the debug I/O, opposite the LED status outputs.
- Raw pad inputs are asynchronous. They are synchronized, debounced per key by a counter state machine, and decoded into press, release and long-press pulses for the test/control logic.

Parameters:
- NUM_KEYS, 4, number of independent keys.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be >= 2.
- LONG_PRESS_CYCLES, 100_000_000, cycles a key must be held after acceptance before key_long fires (2 s at 50 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pad reads 0 when pressed; 0 = pad reads 1 when pressed.

Ports:
- clk  input  1  system clock, XTAL 50 MHz.
- rst  input  1  synchronous, active-high reset.
- keys_raw  input  NUM_KEYS  raw asynchronous key pads.
- key_state  output  NUM_KEYS  debounced level per key, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle pulse when a press is accepted.
- key_release  output  NUM_KEYS  1-cycle pulse when a release is accepted.
- key_long  output  NUM_KEYS  1-cycle pulse once per press at the long-press threshold.

Behaviour:
- Reset: one clock; synchronous active-high; all state changes on posedge clk.
- While rst = 1:
  - key_state, key_press, key_release, key_long = 0.
  - All counters = 0; every FSM = IDLE.
  - Synchronizer flops load the released pad level, so leaving reset never produces a spurious edge.
  - Reset mid-debounce or mid-hold discards all progress; no pulses are emitted for the aborted press.
- Input conditioning:
  - 2-flop synchronizer per key.
  - Polarity normalized after the synchronizer: p = pressed level (1 = pressed), per ACTIVE_LOW.
- Per-key FSM with one debounce counter (width clog2(DEBOUNCE_CYCLES+1)) and one hold counter (width clog2(LONG_PRESS_CYCLES+1)).
- IDLE (key_state = 0):
  - p = 1 -> PRESS_DB, counter = 1.
- PRESS_DB:
  - p = 0 -> IDLE, counter = 0 (bounce rejected, no pulse).
  - p = 1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; key_state = 1 and key_press = 1 on that same edge; hold counter = 0.
  - Otherwise counter + 1.
- PRESSED (key_state = 1):
  - Hold counter increments each cycle and saturates at LONG_PRESS_CYCLES.
  - key_long pulses on the edge where the hold counter goes from LONG_PRESS_CYCLES-1 to LONG_PRESS_CYCLES. This happens at most once per accepted press.
  - p = 0 -> RELEASE_DB, debounce counter = 1.
- RELEASE_DB (key_state stays 1):
  - Hold counter keeps counting, and key_long may fire here.
  - p = 1 -> PRESSED, debounce counter = 0 (bounce rejected).
  - p = 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; key_state = 0 and key_release = 1 on that edge; hold counter = 0.
- Latency: a clean raw edge is reflected on key_state / key_press / key_release exactly DEBOUNCE_CYCLES + 2 clocks later (2 synchronizer + DEBOUNCE_CYCLES debounce).
- Simultaneous events:
  - Keys are fully independent; any combination of pulses may occur in the same cycle.
  - key_press and key_release are never both 1 for one key in one cycle.
  - key_long and key_release can coincide only if the threshold is hit on the release-accept edge. Both are then asserted.
- Key held through reset deassertion: treated as a new press and debounced normally, so key_press fires DEBOUNCE_CYCLES + 2 clocks after rst falls.
- Outputs are registered; no combinational path from keys_raw to any output.

Test Plan (sim with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1, NUM_KEYS=4):
- Clean press: rst 3 cycles, then keys_raw[0] 1->0 held 20 cycles -> key_state[0]=1 and key_press[0] one-cycle pulse exactly 10 clocks after the edge; other keys unchanged.
- Bounce rejection: keys_raw[1] low 5 cycles, high 1 cycle, low 5 cycles, then high -> no key_press[1] and key_state[1] stays 0. The same glitch pattern on release of a held key -> key_state stays 1, no key_release.
- Release: after the clean press, keys_raw[0] 0->1 -> key_release[0] pulse and key_state[0]=0 exactly 10 clocks after the rising edge.
- Long press: hold keys_raw[2] low 60 cycles -> key_press at +10; exactly one key_long[2] pulse 32 clocks after key_press; none afterwards; key_release after the key goes high.
- Reset mid-hold: hold keys_raw[3] low, assert rst at hold count 20 for 2 cycles, keep the key low -> all outputs 0 during reset; key_press[3] 10 clocks after rst falls; key_long 32 clocks after that.
- Concurrency: press keys 0 and 2 on the same cycle -> key_press = 4'b0101 in a single cycle; release both together -> key_release = 4'b0101 in a single cycle.

Source files
------------

// File: rtl/key_input.sv
// key_input: synchronizes, debounces and decodes board push-buttons into a
// clean per-key pressed level plus one-cycle press, release and long-press
// pulses. Every key has its own synchronizer, FSM and counters.
//
// Handshake note: there is no valid/ready pairing here. key_state is a level.
// key_press, key_release and key_long are single-cycle strobes that the
// consumer samples on every clock. All outputs are registered, so there is no
// combinational path from keys_raw to any output.
module key_input #(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);

  // Pad level of a released key; the synchronizer resets to it so that
  // leaving reset never looks like an edge.
  localparam logic RELEASED_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          s0_q, s1_q;
    logic          p;
    state_t        state_q, state_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, press_q, release_q, long_q;
    logic          level_d, press_d, release_d, long_d;

    // Two-flop synchronizer for the asynchronous pad.
    always_ff @(posedge clk) begin
      if (rst) begin
        s0_q <= RELEASED_LVL;
        s1_q <= RELEASED_LVL;
      end else begin
        s0_q <= keys_raw[i];
        s1_q <= s0_q;
      end
    end

    // Normalized pressed level: 1 = pressed regardless of pad polarity.
    assign p = (ACTIVE_LOW != 0) ? ~s1_q : s1_q;

    // Next-state, counter and pulse decode for this key.
    always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      // Hold time runs for the whole accepted press, including release debounce.
      if (state_q == PRESSED || state_q == RELEASE_DB) begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
        if (hold_q == HOLD_PRE) begin
          long_d = 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (p) begin
            state_d = PRESS_DB;
            db_d    = DB_ONE;
          end
        end
        PRESS_DB: begin
          if (!p) begin
            state_d = IDLE;
            db_d    = '0;
          end else if (db_q == DB_LAST) begin
            state_d = PRESSED;
            db_d    = '0;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end
        PRESSED: begin
          if (!p) begin
            state_d = RELEASE_DB;
            db_d    = DB_ONE;
          end
        end
        RELEASE_DB: begin
          if (p) begin
            state_d = PRESSED;
            db_d    = '0;
          end else if (db_q == DB_LAST) begin
            state_d   = IDLE;
            db_d      = '0;
            hold_d    = '0;
            release_d = 1'b1;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          db_d    = '0;
          hold_d  = '0;
        end
      endcase

      level_d = (state_d == PRESSED) || (state_d == RELEASE_DB);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        db_q      <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        db_q      <= db_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign key_state[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_input.sv
// tb_key_input: directed and randomized stimulus for key_input, checked by a
// per-cycle reference model and an event scoreboard.
module tb_key_input;

  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys_raw = 4'hF;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  always #5 clk = ~clk;

  key_input #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .key_long(key_long)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [47:0]   exp_q[$];       // {cycle, state, press, release, long}
  logic [NK-1:0] exp_state = '0;
  logic [NK-1:0] seen_press = '0, seen_release = '0;

  // ---------------- reference model ----------------
  // Per key: the pressed level reaches the debouncer two clocks after the pad;
  // the accepted level flips once DEB consecutive samples disagree with it;
  // long fires when the accepted press has lasted LONG clocks.
  logic d1[NK], d2[NK], lvl[NK];
  int   run[NK], age[NK];

  initial begin
    for (int k = 0; k < NK; k++) begin
      d1[k] = 1'b0; d2[k] = 1'b0; lvl[k] = 1'b0; run[k] = 0; age[k] = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [NK-1:0] pr, rl, lg, st;
    logic          pn;
    @(posedge clk);
    cyc++;
    pr = '0; rl = '0; lg = '0;
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        d1[k] = 1'b0; d2[k] = 1'b0; lvl[k] = 1'b0; run[k] = 0; age[k] = 0;
      end else begin
        pn    = d2[k];
        d2[k] = d1[k];
        d1[k] = ~keys_raw[k];
        if (lvl[k]) begin
          age[k]++;
          if (age[k] == LONG) lg[k] = 1'b1;
        end
        if (pn != lvl[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DEB) begin
          run[k] = 0;
          lvl[k] = ~lvl[k];
          if (lvl[k]) begin
            pr[k]  = 1'b1;
            age[k] = 0;
          end else begin
            rl[k] = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < NK; k++) st[k] = lvl[k];
    exp_state = st;
    if ((pr | rl | lg) != '0) exp_q.push_back({cyc, st, pr, rl, lg});
    #1;
    seen_press   = seen_press | key_press;
    seen_release = seen_release | key_release;
  endtask

  task automatic step_n(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  function automatic logic [NK-1:0] sel(input int kind);
    case (kind)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  // Wait for a pulse of the given kind on any key in mask; check that it came
  // after exactly 'delay' clocks and covered the whole mask in one cycle.
  task automatic wait_evt(input int kind, input logic [NK-1:0] mask,
                          input int delay, input string name);
    int            n = 0;
    logic [NK-1:0] v = '0;
    bit            hit = 0;
    while (!hit && n < 100) begin
      step();
      n++;
      v = sel(kind) & mask;
      if (v != '0) hit = 1;
    end
    checks++;
    if (!hit || n != delay || v != mask) begin
      errors++;
      $display("FAIL %s: got pulse %b after %0d clocks (seen=%0d), required %b after %0d",
               name, v, n, hit, mask, delay);
    end
  endtask

  task automatic check_bits(input logic [NK-1:0] act, input logic [NK-1:0] req,
                            input string name);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [47:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (key_state !== exp_state) begin
        errors++;
        $display("FAIL state@%0d: got %b, required %b", cyc, key_state, exp_state);
      end
      if ((key_press | key_release | key_long) !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event@%0d: got p=%b r=%b l=%b, required none",
                   cyc, key_press, key_release, key_long);
        end else begin
          e = exp_q.pop_front();
          if ({cyc, key_state, key_press, key_release, key_long} !== e) begin
            errors++;
            $display("FAIL event@%0d: got s=%b p=%b r=%b l=%b, required cyc=%0d s=%b p=%b r=%b l=%b",
                     cyc, key_state, key_press, key_release, key_long,
                     e[47:16], e[15:12], e[11:8], e[7:4], e[3:0]);
          end
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][47:16]) <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missed_event@%0d: got none, required p=%b r=%b l=%b",
                 cyc, e[11:8], e[7:4], e[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int            timer[NK];
    logic [NK-1:0] nr;

    rst = 1'b1; keys_raw = 4'hF;
    step_n(3);
    check_bits(key_state | key_press | key_release | key_long, 4'b0000, "reset_outputs");
    rst = 1'b0;

    // Clean press on key 0.
    keys_raw[0] = 1'b0;
    wait_evt(0, 4'b0001, DEB + 2, "clean_press0");
    check_bits(key_state, 4'b0001, "state_after_press0");
    step_n(10);

    // Bounce on key 1 must be rejected.
    seen_press = '0;
    keys_raw[1] = 1'b0; step_n(5);
    keys_raw[1] = 1'b1; step_n(1);
    keys_raw[1] = 1'b0; step_n(5);
    keys_raw[1] = 1'b1; step_n(20);
    check_bits(seen_press & 4'b0010, 4'b0000, "bounce_no_press1");
    check_bits(key_state & 4'b0010, 4'b0000, "bounce_state1");

    // Same glitch on release of held key 0 must keep it pressed.
    seen_release = '0;
    keys_raw[0] = 1'b1; step_n(5);
    keys_raw[0] = 1'b0; step_n(1);
    keys_raw[0] = 1'b1; step_n(5);
    keys_raw[0] = 1'b0; step_n(12);
    check_bits(seen_release & 4'b0001, 4'b0000, "glitch_no_release0");
    check_bits(key_state & 4'b0001, 4'b0001, "glitch_state0");

    // Clean release of key 0.
    keys_raw[0] = 1'b1;
    wait_evt(1, 4'b0001, DEB + 2, "clean_release0");
    check_bits(key_state, 4'b0000, "state_after_release0");

    // Long press on key 2: held 60 cycles in total.
    keys_raw[2] = 1'b0;
    wait_evt(0, 4'b0100, DEB + 2, "long_press2");
    wait_evt(2, 4'b0100, LONG, "long_pulse2");
    step_n(18);
    keys_raw[2] = 1'b1;
    wait_evt(1, 4'b0100, DEB + 2, "long_release2");

    // Reset at hold count 20 on key 3, key kept down through reset.
    keys_raw[3] = 1'b0;
    wait_evt(0, 4'b1000, DEB + 2, "pre_reset_press3");
    step_n(20);
    rst = 1'b1;
    step_n(2);
    check_bits(key_state | key_press | key_release | key_long, 4'b0000, "mid_hold_reset");
    rst = 1'b0;
    wait_evt(0, 4'b1000, DEB + 2, "post_reset_press3");
    wait_evt(2, 4'b1000, LONG, "post_reset_long3");
    keys_raw[3] = 1'b1;
    wait_evt(1, 4'b1000, DEB + 2, "release3");

    // Keys 0 and 2 together.
    keys_raw = 4'b1010;
    wait_evt(0, 4'b0101, DEB + 2, "concurrent_press");
    step_n(5);
    keys_raw = 4'b1111;
    wait_evt(1, 4'b0101, DEB + 2, "concurrent_release");

    // Randomized bouncy traffic with occasional resets.
    for (int k = 0; k < NK; k++) timer[k] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      nr = keys_raw;
      for (int k = 0; k < NK; k++) begin
        if (timer[k] == 0) begin
          nr[k]    = ~nr[k];
          timer[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                 : $urandom_range(8, 60);
        end else begin
          timer[k]--;
        end
      end
      keys_raw = nr;
      rst = ($urandom_range(0, 599) == 0);
      step();
    end

    // Drain: release everything and let pending events complete.
    rst = 1'b0; keys_raw = 4'hF;
    step_n(80);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      logic [47:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_event: got none, required cyc=%0d p=%b r=%b l=%b",
               e[47:16], e[11:8], e[7:4], e[3:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
